xtea_dec: RTL

XTEA_DEC -- requirements
Module: xtea_dec

---
 rtl/xtea_dec.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/xtea_dec.sv
// rtl/xtea_dec.sv - XTEA block decryptor, one cycle per edge; XTEA_DEC_ABORT_EN adds an abort input
module xtea_dec #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         reset,
`ifdef XTEA_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_dec,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_dec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] DELTA    = 32'h9E3779B9;
  localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);

  state_t        state_q, state_d;
  logic [31:0]   v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   out_dec_q, out_dec_d;

  logic [31:0]   rnd_v0, rnd_v1, rnd_sum;
  logic          abort_hit;

  // k0 lives in the most significant word of the key
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] s);
    case (s)
      2'd0:    key_word = k[127:96];
      2'd1:    key_word = k[95:64];
      2'd2:    key_word = k[63:32];
      default: key_word = k[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] v);
    mix = ((v << 4) ^ (v >> 5)) + v;
  endfunction

  // Abort only acts on a block in flight; in IDLE it must not block a handshake
`ifdef XTEA_DEC_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // One full decryption cycle; v0 uses the freshly updated v1 and sum
  always_comb begin
    rnd_v1  = v1_q - (mix(v0_q) ^ (sum_q + key_word(key_q, sum_q[12:11])));
    rnd_sum = sum_q - DELTA;
    rnd_v0  = v0_q - (mix(rnd_v1) ^ (rnd_sum + key_word(key_q, rnd_sum[1:0])));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          v0_d       = in_dec[63:32];
          v1_d       = in_dec[31:0];
          key_d      = key;
          sum_d      = SUM_INIT;
          cnt_d      = 7'(ROUNDS);
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        v0_d  = rnd_v0;
        v1_d  = rnd_v1;
        sum_d = rnd_sum;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          out_valid_d = 1'b1;
          out_dec_d   = {rnd_v0, rnd_v1};
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_dec_d   = '0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_dec_d   = '0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
    if (abort_hit) begin
      out_valid_d = 1'b0;
      out_dec_d   = '0;
      in_ready_d  = 1'b1;
      state_d     = IDLE;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dec   = out_dec_q;

endmodule
